decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage for the pipelined CPU. It sits between the fetch/decode pipeline latch and the execute stage. It splits a fetched instruction word into fields and decodes the opcode into a one-hot class vector with an illegal-opcode flag. It also generates the two decode-side stalls, load-use and multiply/divide busy, and honours a branch flush. Its valid/ready handshakes let it absorb downstream back-pressure.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/opcode_class_dec.sv | 55 +++++
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared decode constants for the pipelined CPU: opcode map,
//               mul/div ALU op codes and one-hot class bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int NUM_CLS = 11;

  // Opcode map (low five opcode bits)
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops that occupy the multi-cycle multiply/divide unit
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Bit positions inside the one-hot class vector
  localparam int CLS_RTYPE = 0;
  localparam int CLS_ADDI  = 1;
  localparam int CLS_SW    = 2;
  localparam int CLS_LW    = 3;
  localparam int CLS_J     = 4;
  localparam int CLS_BNE   = 5;
  localparam int CLS_JAL   = 6;
  localparam int CLS_JR    = 7;
  localparam int CLS_BLT   = 8;
  localparam int CLS_BEX   = 9;
  localparam int CLS_SETX  = 10;

endpackage
`default_nettype wire

// File: rtl/opcode_class_dec.sv
`default_nettype none
// ============================================================================
// Module      : opcode_class_dec
// Description : Combinational opcode classifier. Produces a one-hot class
//               vector and an illegal flag; any set opcode bit above bit 4
//               makes the opcode illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_class_dec
  import cpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0]    opcode,
  output logic [NUM_CLS-1:0] op_class,
  output logic               illegal
);

  logic [4:0] op_lo;
  logic       hi_zero;

  generate
    if (OP_W > 5) begin : g_wide
      assign op_lo   = opcode[4:0];
      assign hi_zero = ~|opcode[OP_W-1:5];
    end else begin : g_narrow
      assign op_lo   = 5'(opcode);
      assign hi_zero = 1'b1;
    end
  endgenerate

  // Map the opcode onto exactly one class bit, or none when unrecognised
  always_comb begin
    op_class = '0;
    if (hi_zero) begin
      case (op_lo)
        OP_RTYPE: op_class[CLS_RTYPE] = 1'b1;
        OP_J:     op_class[CLS_J]     = 1'b1;
        OP_BNE:   op_class[CLS_BNE]   = 1'b1;
        OP_JAL:   op_class[CLS_JAL]   = 1'b1;
        OP_JR:    op_class[CLS_JR]    = 1'b1;
        OP_ADDI:  op_class[CLS_ADDI]  = 1'b1;
        OP_BLT:   op_class[CLS_BLT]   = 1'b1;
        OP_SW:    op_class[CLS_SW]    = 1'b1;
        OP_LW:    op_class[CLS_LW]    = 1'b1;
        OP_SETX:  op_class[CLS_SETX]  = 1'b1;
        OP_BEX:   op_class[CLS_BEX]   = 1'b1;
        default:  op_class = '0;
      endcase
    end
    illegal = ~|op_class;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered instruction-decode stage with valid/ready
//               handshakes, load-use and mul/div stall generation and
//               branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import cpu_pkg::*;
#(
  parameter int INSN_W     = 32,
  parameter int OP_W       = 5,
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [INSN_W-1:0]      in_insn,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CLS-1:0]     out_class,
  output logic                   out_illegal,
  output logic [REG_W-1:0]       out_rd,
  output logic [REG_W-1:0]       out_rs,
  output logic [REG_W-1:0]       out_rt,
  output logic [4:0]             out_shamt,
  output logic [4:0]             out_aluop,
  output logic [INSN_W-1:0]      out_imm,
  output logic [INSN_W-OP_W-1:0] out_target,
  output logic                   md_busy
);

  localparam int IMM_W = INSN_W - OP_W - 2*REG_W;
  localparam int TGT_W = INSN_W - OP_W;
  localparam int RD_HI = TGT_W - 1;
  localparam int RS_HI = RD_HI - REG_W;
  localparam int RT_HI = RS_HI - REG_W;
  localparam int SH_HI = RT_HI - REG_W;
  localparam int AL_HI = SH_HI - 5;

  // Field slices of the incoming word
  logic [REG_W-1:0]   in_rd, in_rs, in_rt;
  logic [4:0]         in_shamt, in_aluop;
  logic [INSN_W-1:0]  in_imm;
  logic [TGT_W-1:0]   in_target;
  logic [NUM_CLS-1:0] in_class;
  logic               in_illegal;

  assign in_rd     = in_insn[RD_HI -: REG_W];
  assign in_rs     = in_insn[RS_HI -: REG_W];
  assign in_rt     = in_insn[RT_HI -: REG_W];
  assign in_shamt  = in_insn[SH_HI -: 5];
  assign in_aluop  = in_insn[AL_HI -: 5];
  assign in_imm    = {{(INSN_W-IMM_W){in_insn[IMM_W-1]}}, in_insn[IMM_W-1:0]};
  assign in_target = in_insn[TGT_W-1:0];

  opcode_class_dec #(.OP_W(OP_W)) u_dec (
    .opcode   (in_insn[INSN_W-1 -: OP_W]),
    .op_class (in_class),
    .illegal  (in_illegal)
  );

  // Registered state
  logic               out_valid_q, out_valid_d;
  logic [NUM_CLS-1:0] out_class_q, out_class_d;
  logic               out_illegal_q, out_illegal_d;
  logic [REG_W-1:0]   out_rd_q, out_rd_d, out_rs_q, out_rs_d, out_rt_q, out_rt_d;
  logic [4:0]         out_shamt_q, out_shamt_d, out_aluop_q, out_aluop_d;
  logic [INSN_W-1:0]  out_imm_q, out_imm_d;
  logic [TGT_W-1:0]   out_target_q, out_target_d;
  logic [7:0]         md_cnt_q, md_cnt_d;

  logic load_use, accept, is_muldiv;

  // Hazards, handshake and next-state selection
  always_comb begin
    load_use  = in_valid & out_valid_q & out_class_q[CLS_LW] & (out_rd_q != '0) &
                ((out_rd_q == in_rs) | (out_rd_q == in_rt));
    in_ready  = (md_cnt_q == 8'd0) & ~load_use & (~out_valid_q | out_ready);
    accept    = in_valid & in_ready & ~flush;
    is_muldiv = in_class[CLS_RTYPE] & ((in_aluop == ALU_MUL) | (in_aluop == ALU_DIV));

    out_class_d   = out_class_q;
    out_illegal_d = out_illegal_q;
    out_rd_d      = out_rd_q;
    out_rs_d      = out_rs_q;
    out_rt_d      = out_rt_q;
    out_shamt_d   = out_shamt_q;
    out_aluop_d   = out_aluop_q;
    out_imm_d     = out_imm_q;
    out_target_d  = out_target_q;
    out_valid_d   = out_valid_q & ~out_ready;
    md_cnt_d      = (md_cnt_q != 8'd0) ? md_cnt_q - 8'd1 : 8'd0;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_class_d   = in_class;
      out_illegal_d = in_illegal;
      out_rd_d      = in_rd;
      out_rs_d      = in_rs;
      out_rt_d      = in_rt;
      out_shamt_d   = in_shamt;
      out_aluop_d   = in_aluop;
      out_imm_d     = in_imm;
      out_target_d  = in_target;
      if (is_muldiv) md_cnt_d = 8'(MD_LATENCY);
    end

    // A taken branch kills both the held and the incoming instruction
    if (flush) begin
      out_valid_d = 1'b0;
      md_cnt_d    = 8'd0;
    end
  end

  // State update with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_class_q   <= '0;
      out_illegal_q <= 1'b0;
      out_rd_q      <= '0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_shamt_q   <= '0;
      out_aluop_q   <= '0;
      out_imm_q     <= '0;
      out_target_q  <= '0;
      md_cnt_q      <= 8'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_class_q   <= out_class_d;
      out_illegal_q <= out_illegal_d;
      out_rd_q      <= out_rd_d;
      out_rs_q      <= out_rs_d;
      out_rt_q      <= out_rt_d;
      out_shamt_q   <= out_shamt_d;
      out_aluop_q   <= out_aluop_d;
      out_imm_q     <= out_imm_d;
      out_target_q  <= out_target_d;
      md_cnt_q      <= md_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_class   = out_class_q;
  assign out_illegal = out_illegal_q;
  assign out_rd      = out_rd_q;
  assign out_rs      = out_rs_q;
  assign out_rt      = out_rt_q;
  assign out_shamt   = out_shamt_q;
  assign out_aluop   = out_aluop_q;
  assign out_imm     = out_imm_q;
  assign out_target  = out_target_q;
  assign md_busy     = (md_cnt_q != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. A driver predicts the
//               handshake from a behavioural model and queues the expected
//               decode of each accepted word; a monitor pops and compares
//               whenever the stage hands an output to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_insn;
  logic        in_ready, out_valid, out_illegal, md_busy;
  logic [10:0] out_class;
  logic [4:0]  out_rd, out_rs, out_rt, out_shamt, out_aluop;
  logic [31:0] out_imm;
  logic [26:0] out_target;

  decode_stage #(.INSN_W(32), .OP_W(5), .REG_W(5), .MD_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_insn(in_insn),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_illegal(out_illegal), .out_rd(out_rd), .out_rs(out_rs),
    .out_rt(out_rt), .out_shamt(out_shamt), .out_aluop(out_aluop), .out_imm(out_imm),
    .out_target(out_target), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

  // Opcode of each class, indexed by class bit position
  int op_tab [11] = '{0, 5, 7, 8, 1, 2, 3, 4, 6, 22, 21};

  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [95:0] exp_q [$];

  // Reference model state: held instruction and remaining busy cycles
  bit          m_valid;
  logic [31:0] m_held;
  int          m_busy;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [95:0] expect_of(input logic [31:0] w);
    int          op  = int'(w >> 27);
    int          idx = -1;
    int          imm = int'(w & 32'h1FFFF);
    logic [10:0] cls = '0;
    for (int k = 0; k < 11; k++) if (op_tab[k] == op) idx = k;
    if (idx >= 0) cls = 11'd1 << idx;
    if (imm >= 65536) imm = imm - 131072;
    return {cls, (idx < 0), 5'((w >> 22) & 31), 5'((w >> 17) & 31), 5'((w >> 12) & 31),
            5'((w >> 7) & 31), 5'((w >> 2) & 31), 32'(imm), 27'(w & 32'h7FFFFFF)};
  endfunction

  function automatic bit is_muldiv(input logic [31:0] w);
    int al = int'((w >> 2) & 31);
    return ((w >> 27) == 0) && (al == 6 || al == 7);
  endfunction

  function automatic bit model_ready(input bit v, input logic [31:0] w, input bit ordy);
    int hrd = int'((m_held >> 22) & 31);
    int rs  = int'((w >> 17) & 31);
    int rt  = int'((w >> 12) & 31);
    bit lu  = v && m_valid && ((m_held >> 27) == 8) && hrd != 0 && (hrd == rs || hrd == rt);
    return (m_busy == 0) && !lu && (!m_valid || ordy);
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the rising edge
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                      output bit acc);
    bit er;
    in_valid = v; in_insn = w; out_ready = ordy; flush = fl;
    #1;
    er = model_ready(v, w, ordy);
    chk("in_ready", 96'(in_ready), 96'(er));
    chk("md_busy", 96'(md_busy), 96'(m_busy != 0));
    acc = v && er && !fl;
    @(posedge clock);
    #1;
    if (fl) begin
      m_valid = 1'b0;
      m_busy  = 0;
    end else begin
      if (acc && is_muldiv(w)) m_busy = L;
      else if (m_busy > 0) m_busy--;
      if (acc) begin
        m_valid = 1'b1;
        m_held  = w;
        exp_q.push_back(expect_of(w));
      end else if (ordy) m_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, a);
  endtask

  // Offer a word with out_ready high until accepted; returns stall cycles
  task automatic offer(input logic [31:0] w, output int stalls);
    bit a = 1'b0;
    stalls = 0;
    for (int i = 0; i < 50 && !a; i++) begin
      step(1'b1, w, 1'b1, 1'b0, a);
      if (!a) stalls++;
    end
    if (!a) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: word %h never accepted", w);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; in_insn = '0; flush = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    m_valid = 1'b0; m_held = '0; m_busy = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_md_busy", 96'(md_busy), 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(1));
    chk("rst_fields", {out_class, out_illegal, out_rd, out_rs, out_rt, out_shamt,
                       out_aluop, out_imm, out_target}, 96'(0));
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input int al);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(al), 2'b00};
  endfunction

  function automatic logic [31:0] rand_insn();
    int          pick = $urandom_range(0, 13);
    logic [4:0]  op   = (pick < 11) ? 5'(op_tab[pick]) : 5'($urandom);
    logic [31:0] w    = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 12'($urandom)};
    if (op == 5'd0 && $urandom_range(0, 2) == 0) w[6:2] = 5'($urandom_range(6, 7));
    return w;
  endfunction

  // Monitor: one expected entry per held output; compare on each hand-off
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        chk("valid_track", 96'(out_valid), 96'(exp_q.size() != 0));
        if (out_valid && exp_q.size() > 0) begin
          if (flush) void'(exp_q.pop_front());
          else if (out_ready) begin
            e = exp_q.pop_front();
            chk("decode", {out_class, out_illegal, out_rd, out_rs, out_rt, out_shamt,
                           out_aluop, out_imm, out_target}, e);
          end
        end
      end
    end
  end

  initial begin
    bit a;
    int s;
    reset_dut();
    mon_en = 1'b1;

    // Back-to-back stream: addi r3,r1,-5 then j 0x100
    offer(enc_i(5, 3, 1, -5), s);
    offer({5'd1, 27'h100}, s);
    idle(2);

    // Load-use: one bubble, none when the load targets r0
    offer(enc_i(8, 4, 2, 0), s);
    offer(enc_r(5, 4, 6, 0), s);
    chk("load_use_bubbles", 96'(s), 96'(1));
    offer(enc_i(8, 0, 2, 0), s);
    offer(enc_r(5, 0, 6, 0), s);
    chk("r0_no_bubble", 96'(s), 96'(0));
    idle(1);

    // Multiply busy period
    offer(enc_r(1, 2, 3, 6), s);
    offer(enc_i(5, 9, 1, 7), s);
    chk("mul_stall_cycles", 96'(s), 96'(L));
    idle(1);

    // Back-pressure: hold the output for five cycles, including an offer
    offer(enc_i(5, 7, 2, 1234), s);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, a);
    step(1'b1, enc_i(5, 1, 1, 1), 1'b0, 1'b0, a);
    idle(2);

    // Flush while a divide is held and the unit is busy
    offer(enc_r(2, 3, 1, 7), s);
    step(1'b0, 32'h0, 1'b0, 1'b0, a);
    step(1'b1, enc_i(5, 1, 1, 1), 1'b0, 1'b1, a);
    chk("flush_out_valid", 96'(out_valid), 96'(0));
    chk("flush_md_busy", 96'(md_busy), 96'(0));
    idle(1);

    // Illegal opcode
    offer({5'b11111, 27'h0123456}, s);
    idle(1);

    // Reset in the middle of a mul stall
    offer(enc_r(3, 1, 2, 6), s);
    step(1'b0, 32'h0, 1'b1, 1'b0, a);
    reset_dut();

    // Randomised traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 8, rand_insn(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, a);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
